// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
//   Shared types and helpers for the dual-clock FIFO control logic.
//   - rd_arb_state_t : read-side burst scheduler states
//   - rr_pick        : round-robin pick, returns a one-hot vector (up to RR_MAX
//                      requesters); the first set request after 'ptr' wins,
//                      wrapping around.
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, DRAIN} rd_arb_state_t;

  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDX_W = 5;

  // 'n' is the number of live requesters (2..RR_MAX); bits above n-1 are ignored.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input int unsigned       ptr,
                                                input int unsigned       n);
    logic [RR_MAX-1:0]   pick;
    logic                found;
    logic [RR_IDX_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      idx = RR_IDX_W'((ptr + i) % n);
      if ((i <= n) && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter: the first asserted request after the
//   pointer wins (wrapping around).
//   Ports:
//     req_i  [NREQ]        request vector
//     ptr_i  [log2 NREQ]   index of the previous winner
//     gnt_o  [NREQ]        one-hot winner (all zero when no request)
//     idx_o  [log2 NREQ]   binary index of the winner
//     any_o                at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IDX_W = $clog2(NREQ);

  logic [RR_MAX-1:0] pick;

  assign pick  = rr_pick(RR_MAX'(req_i), 32'(ptr_i), NREQ);
  assign gnt_o = pick[NREQ-1:0];
  assign any_o = |pick;

  always_comb begin
    idx_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k]) idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/fifo_rd_burst_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rd_burst_arbiter
//   Read-side burst scheduler for the dual-clock FIFO (read clock domain).
//   Shares the FIFO read port between NREQ consumers with round-robin
//   arbitration; a granted burst starts only once enough words are available.
//   Ports:
//     rd_clk_i       FIFO read clock (sole clock)
//     aclr_i         async active-low reset (shared with the FIFO)
//     req_i          per-requester burst request, level, held until granted
//     req_len_i      burst lengths, requester k at [k*BLEN_W +: BLEN_W]
//     fifo_empty_i   FIFO rd_empty
//     fifo_usedw_i   FIFO rd_usedw (lagging, conservative)
//     fifo_q_i       FIFO read data, valid one cycle after an accepted read
//     fifo_rd_req_o  FIFO read request
//     gnt_o          one-hot grant, high for the whole burst
//     data_o         read data pass-through, qualified by data_valid_o
//     data_valid_o   data_o holds a word for the granted requester
//     burst_done_o   one-cycle pulse on the last word of a burst
// -----------------------------------------------------------------------------
module fifo_rd_burst_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3,
  parameter int NREQ   = 4,
  parameter int BLEN_W = 4
) (
  input  logic                     rd_clk_i,
  input  logic                     aclr_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*BLEN_W-1:0]   req_len_i,
  input  logic                     fifo_empty_i,
  input  logic [AWIDTH-1:0]        fifo_usedw_i,
  input  logic [DWIDTH-1:0]        fifo_q_i,
  output logic                     fifo_rd_req_o,
  output logic [NREQ-1:0]          gnt_o,
  output logic [DWIDTH-1:0]        data_o,
  output logic                     data_valid_o,
  output logic [NREQ-1:0]          burst_done_o
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam int IDX_W = $clog2(NREQ);
  localparam int AVW   = AWIDTH + 1;
  localparam int CW    = (BLEN_W > AVW) ? BLEN_W : AVW;

  rd_arb_state_t     state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [BLEN_W-1:0] len_q;
  logic [BLEN_W-1:0] issued_q;
  logic [BLEN_W-1:0] issued_d;
  logic              vld_q;

  logic [NREQ-1:0]   elig;
  logic [BLEN_W-1:0] win_len;
  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  logic [AVW-1:0]    avail;
  logic [CW-1:0]     avail_c;
  logic [CW-1:0]     need_c;
  logic              rd_req;

  // Zero-length requests are never eligible; win_len follows the one-hot winner.
  always_comb begin
    elig    = '0;
    win_len = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = req_i[k] && (req_len_i[k*BLEN_W +: BLEN_W] != '0);
      if (arb_gnt[k]) win_len = req_len_i[k*BLEN_W +: BLEN_W];
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // A full FIFO wraps usedw to 0 while not empty, so report DEPTH in that case.
  assign avail   = ((fifo_usedw_i == '0) && !fifo_empty_i) ? AVW'(DEPTH)
                                                           : {1'b0, fifo_usedw_i};
  assign avail_c = CW'(avail);
  // Bursts longer than the FIFO start once it is full and stall on empty.
  assign need_c  = (CW'(len_q) < CW'(DEPTH)) ? CW'(len_q) : CW'(DEPTH);

  assign rd_req   = (state_q == STREAM) && !fifo_empty_i && (issued_q < len_q);
  assign issued_d = issued_q + BLEN_W'(1);

  always_ff @(posedge rd_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      ptr_q    <= IDX_W'(NREQ - 1);
      len_q    <= '0;
      issued_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q  <= rd_req;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            gnt_q    <= arb_gnt;
            len_q    <= win_len;
            ptr_q    <= arb_idx;
            issued_q <= '0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          // Withdrawn request abandons the burst; the pointer keeps the winner.
          if ((req_i & gnt_q) == '0) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (avail_c >= need_c) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (rd_req) begin
            issued_q <= issued_d;
            if (issued_d == len_q) begin
              done_q  <= gnt_q;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_req_o = rd_req;
  assign gnt_o         = gnt_q;
  assign data_o        = fifo_q_i;
  assign data_valid_o  = vld_q;
  assign burst_done_o  = done_q;

endmodule
